// File: rtl/traffic_pkg.sv
// Shared lamp encodings, state codes and the Moore lamp decode for the intersection controller.
// Pure definitions; no timing or flow control.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam logic [2:0] PH_NS_G  = 3'd0;
  localparam logic [2:0] PH_NS_Y  = 3'd1;
  localparam logic [2:0] PH_AR_A  = 3'd2;
  localparam logic [2:0] PH_EW_G  = 3'd3;
  localparam logic [2:0] PH_EW_Y  = 3'd4;
  localparam logic [2:0] PH_AR_B  = 3'd5;
  localparam logic [2:0] PH_WALK  = 3'd6;
  localparam logic [2:0] PH_FLASH = 3'd7;

  typedef enum logic [2:0] {
    NS_G  = PH_NS_G,
    NS_Y  = PH_NS_Y,
    AR_A  = PH_AR_A,
    EW_G  = PH_EW_G,
    EW_Y  = PH_EW_Y,
    AR_B  = PH_AR_B,
    WALK  = PH_WALK,
    FLASH = PH_FLASH
  } state_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // flash_on only matters in FLASH; every other state has fixed lamps.
  function automatic lamps_t lamp_decode(input state_t s, input logic flash_on);
    lamps_t l;
    l.ns   = LAMP_RED;
    l.ew   = LAMP_RED;
    l.walk = 1'b0;
    case (s)
      NS_G:  l.ns = LAMP_GREEN;
      NS_Y:  l.ns = LAMP_YELLOW;
      EW_G:  l.ew = LAMP_GREEN;
      EW_Y:  l.ew = LAMP_YELLOW;
      WALK:  l.walk = 1'b1;
      FLASH: begin
        l.ns = flash_on ? LAMP_YELLOW : LAMP_OFF;
        l.ew = flash_on ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts tick-qualified edges up to limit-1; done is combinational on tick and cnt.
// No backpressure; clr and rst force the count to zero regardless of tick.
module dwell_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = tick && (cnt == (limit - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (done) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// NS/EW intersection controller with all-red clearance, latched pedestrian walk and night flash.
// Lamps are registered from next-state, so they update on the same edge as phase; no backpressure.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned T_GREEN  = 20,
  parameter int unsigned T_YELLOW = 4,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_WALK   = 10,
  parameter int unsigned T_FLASH  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  state_t           state;
  state_t           state_nxt;
  logic             flash_on;
  logic             flash_nxt;
  logic             ped_nxt;
  logic             clr;
  logic             done;
  logic [CNT_W-1:0] limit;
  lamps_t           lamps_nxt;

  always_comb begin
    limit = CNT_W'(T_FLASH);
    case (state)
      NS_G, EW_G: limit = CNT_W'(T_GREEN);
      NS_Y, EW_Y: limit = CNT_W'(T_YELLOW);
      AR_A, AR_B: limit = CNT_W'(T_ALLRED);
      WALK:       limit = CNT_W'(T_WALK);
      default:    limit = CNT_W'(T_FLASH);
    endcase
  end

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .tick  (tick),
    .limit (limit),
    .done  (done)
  );

  always_comb begin
    state_nxt = state;
    flash_nxt = flash_on;
    clr       = 1'b0;
    case (state)
      NS_G: if (done) state_nxt = NS_Y;
      NS_Y: if (done) state_nxt = AR_A;
      AR_A: if (done) state_nxt = flash_mode ? FLASH : EW_G;
      EW_G: if (done) state_nxt = EW_Y;
      EW_Y: if (done) state_nxt = AR_B;
      AR_B: begin
        if (done) begin
          if (flash_mode)       state_nxt = FLASH;
          else if (ped_pending) state_nxt = WALK;
          else                  state_nxt = NS_G;
        end
      end
      WALK: if (done) state_nxt = flash_mode ? FLASH : NS_G;
      FLASH: begin
        // Leaving flash is immediate and does not wait for a tick.
        if (!flash_mode) begin
          state_nxt = AR_B;
          flash_nxt = 1'b0;
          clr       = 1'b1;
        end else if (done) begin
          flash_nxt = ~flash_on;
        end
      end
      default: state_nxt = AR_B;
    endcase

    if (state != FLASH && state_nxt == FLASH) begin
      flash_nxt = 1'b1;
    end

    // Serving the request on WALK entry takes priority over a simultaneous new request.
    if (state != WALK && state_nxt == WALK) begin
      ped_nxt = 1'b0;
    end else begin
      ped_nxt = ped_pending | ped_req;
    end

    lamps_nxt = lamp_decode(state_nxt, flash_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= AR_B;
      flash_on    <= 1'b0;
      ped_pending <= 1'b0;
      light_ns    <= LAMP_RED;
      light_ew    <= LAMP_RED;
      walk        <= 1'b0;
    end else begin
      state       <= state_nxt;
      flash_on    <= flash_nxt;
      ped_pending <= ped_nxt;
      light_ns    <= lamps_nxt.ns;
      light_ew    <= lamps_nxt.ew;
      walk        <= lamps_nxt.walk;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Table-driven bench for traffic_light_ctrl with short dwell times and a scoreboard of expected outputs.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       ped_req;
  logic       flash_mode;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  traffic_light_ctrl #(
    .CNT_W    (16),
    .T_GREEN  (3),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_WALK   (2),
    .T_FLASH  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .ped_req     (ped_req),
    .flash_mode  (flash_mode),
    .light_ns    (light_ns),
    .light_ew    (light_ew),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       t;
    logic       p;
    logic       f;
    logic [2:0] ph;
    logic       fon;
    logic       pp;
  } vec_t;

  typedef struct {
    logic [2:0] phase;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       pp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   nseq[12] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5};

  function automatic logic [5:0] lamp_exp(input logic [2:0] ph, input logic fon);
    case (ph)
      3'd0:    return {3'b010, 3'b100};
      3'd1:    return {3'b001, 3'b100};
      3'd3:    return {3'b100, 3'b010};
      3'd4:    return {3'b100, 3'b001};
      3'd7:    return fon ? {3'b001, 3'b100} : 6'b000000;
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  task automatic add(input logic r, t, p, f, input int ph, input logic fon, input logic pp);
    vec_t v;
    v.r = r; v.t = t; v.p = p; v.f = f;
    v.ph = 3'(ph); v.fon = fon; v.pp = pp;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, push the expected outputs, then compare after the edge.
  task automatic step(input logic r, t, p, f, input logic [2:0] ph, input logic fon,
                      input logic pp, input string nm);
    exp_t e;
    exp_t got;
    rst = r; tick = t; ped_req = p; flash_mode = f;
    e.phase = ph;
    {e.ns, e.ew} = lamp_exp(ph, fon);
    e.walk = (ph == 3'd6);
    e.pp = pp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got.phase = phase; got.ns = light_ns; got.ew = light_ew; got.walk = walk; got.pp = ped_pending;
    n_checks++;
    if (got == e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got phase=%0d ns=%b ew=%b walk=%b pp=%b, want phase=%0d ns=%b ew=%b walk=%b pp=%b",
               nm, got.phase, got.ns, got.ew, got.walk, got.pp,
               e.phase, e.ns, e.ew, e.walk, e.pp);
    end
  endtask

  task automatic add_reset();
    add(1, 1, 0, 0, 5, 0, 0);
    add(1, 1, 0, 0, 5, 0, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;

    // Normal cycle: 12-cycle period from AR_B.
    add_reset();
    for (int k = 1; k <= 25; k++) add(0, 1, 0, 0, nseq[(k-1)%12], 0, 0);

    // Pedestrian pulse in EW_G, served after AR_B.
    add_reset();
    for (int k = 1; k <= 7; k++) add(0, 1, 0, 0, nseq[k-1], 0, 0);
    add(0, 1, 1, 0, 3, 0, 1);
    add(0, 1, 0, 0, 3, 0, 1);
    add(0, 1, 0, 0, 4, 0, 1);
    add(0, 1, 0, 0, 4, 0, 1);
    add(0, 1, 0, 0, 5, 0, 1);
    add(0, 1, 0, 0, 6, 0, 0);
    add(0, 1, 0, 0, 6, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);

    // Tick gating: freeze for 10 clocks, then one tick every 4th clock.
    add_reset();
    add(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m <= 8; m++) add(0, (m % 4 == 0), 0, 0, (m == 8) ? 1 : 0, 0, 0);
    for (int m = 1; m <= 8; m++) add(0, (m % 4 == 0), 0, 0, (m == 8) ? 2 : 1, 0, 0);

    // Reset mid EW_G with a pending request drops the request.
    add_reset();
    for (int k = 1; k <= 7; k++) add(0, 1, 0, 0, nseq[k-1], 0, 0);
    add(0, 1, 1, 0, 3, 0, 1);
    add(1, 1, 0, 0, 5, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);

    // Request held across WALK entry: clear wins for one cycle, then re-latches.
    add_reset();
    for (int k = 1; k <= 12; k++) add(0, 1, 1, 0, nseq[k-1], 0, 1);
    add(0, 1, 1, 0, 6, 0, 0);
    add(0, 1, 1, 0, 6, 0, 1);
    for (int k = 15; k <= 26; k++) add(0, 1, 0, 0, nseq[k-15], 0, 1);
    add(0, 1, 0, 0, 6, 0, 0);
    add(0, 1, 0, 0, 6, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].p, tbl[i].f, tbl[i].ph, tbl[i].fon, tbl[i].pp,
           $sformatf("vec%0d", i));
    end

    // Flash entry via AR_A, request latched during flash, tick-less exit, then WALK service.
    step(1, 1, 0, 0, 5, 0, 0, "fl_rst0");
    step(1, 1, 0, 0, 5, 0, 0, "fl_rst1");
    step(0, 1, 0, 0, 0, 0, 0, "fl_nsg0");
    step(0, 1, 0, 1, 0, 0, 0, "fl_nsg1");
    step(0, 1, 0, 1, 0, 0, 0, "fl_nsg2");
    step(0, 1, 0, 1, 1, 0, 0, "fl_nsy0");
    step(0, 1, 0, 1, 1, 0, 0, "fl_nsy1");
    step(0, 1, 0, 1, 2, 0, 0, "fl_ara");
    step(0, 1, 0, 1, 7, 1, 0, "fl_on0");
    step(0, 1, 0, 1, 7, 1, 0, "fl_on1");
    step(0, 1, 0, 1, 7, 0, 0, "fl_off0");
    step(0, 1, 1, 1, 7, 0, 1, "fl_off1_ped");
    step(0, 1, 0, 1, 7, 1, 1, "fl_on2");
    step(0, 1, 0, 1, 7, 1, 1, "fl_on3");
    step(0, 1, 0, 1, 7, 0, 1, "fl_off2");
    step(0, 0, 0, 0, 5, 0, 1, "fl_exit_notick");
    step(0, 1, 0, 0, 6, 0, 0, "fl_walk0");
    step(0, 1, 0, 0, 6, 0, 0, "fl_walk1");
    step(0, 1, 0, 0, 0, 0, 0, "fl_nsg_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
